// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin arbiter for the shared 8-bit ALU (optional flags: ALU_ARB_FLAGS_EN)
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic       rsp_zero
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Final EXEC count before the ALU output is considered settled.
  localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
  logic       rsp_zero_q, rsp_zero_d;
`endif

  logic idle;
  logic any_valid;
  logic grant;

  assign idle      = (state_q == ST_IDLE);
  assign any_valid = req0_valid | req1_valid;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready stays low while rst_n is asserted.
  assign req0_ready = rst_n & idle & req0_valid & ~grant;
  assign req1_ready = rst_n & idle & req1_valid & grant;

  // Next-state for the issue / settle / hand-back sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
`ifdef ALU_ARB_FLAGS_EN
    rsp_zero_d   = rsp_zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          alu_op_d     = grant ? req1_op : req0_op;
          alu_a_d      = grant ? req1_a  : req0_a;
          alu_b_d      = grant ? req1_b  : req0_b;
          rsp_id_d     = grant;
          last_grant_d = grant;
          cnt_d        = 3'd0;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          rsp_data_d  = alu_result;
`ifdef ALU_ARB_FLAGS_EN
          rsp_zero_d  = (alu_result == 8'h00);
`endif
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; an async reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      alu_op_q     <= 3'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 8'h00;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero_q   <= rsp_zero_d;
`endif
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
`ifdef ALU_ARB_FLAGS_EN
  assign rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter at ALU_LAT 1 and 3 (honours ALU_ARB_FLAGS_EN)
module tb_alu_share_arbiter;

  localparam int NI = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       o_r0_ready [NI];
  logic       o_r1_ready [NI];
  logic [2:0] o_alu_op [NI];
  logic [7:0] o_alu_a [NI];
  logic [7:0] o_alu_b [NI];
  logic [7:0] i_alu_res [NI];
  logic       o_rsp_valid [NI];
  logic       o_rsp_id [NI];
  logic [7:0] o_rsp_data [NI];
`ifdef ALU_ARB_FLAGS_EN
  logic       o_rsp_zero [NI];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  // Instance 0 sees an instantaneous ALU; instance 1 sees one that settles two cycles late.
  logic [18:0] stub_d1 = '0;
  logic [18:0] stub_d2 = '0;
  always @(posedge clk) begin
    stub_d1 <= {o_alu_op[1], o_alu_a[1], o_alu_b[1]};
    stub_d2 <= stub_d1;
  end
  assign i_alu_res[0] = alu_f(o_alu_op[0], o_alu_a[0], o_alu_b[0]);
  assign i_alu_res[1] = alu_f(stub_d2[18:16], stub_d2[15:8], stub_d2[7:0]);

  alu_share_arbiter #(.ALU_LAT(LAT0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(o_r0_ready[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(o_r1_ready[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(o_alu_op[0]), .alu_a(o_alu_a[0]), .alu_b(o_alu_b[0]), .alu_result(i_alu_res[0]),
    .rsp_valid(o_rsp_valid[0]), .rsp_id(o_rsp_id[0]), .rsp_data(o_rsp_data[0]), .rsp_ready(rsp_ready)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_zero(o_rsp_zero[0])
`endif
  );

  alu_share_arbiter #(.ALU_LAT(LAT1)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(o_r0_ready[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(o_r1_ready[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(o_alu_op[1]), .alu_a(o_alu_a[1]), .alu_b(o_alu_b[1]), .alu_result(i_alu_res[1]),
    .rsp_valid(o_rsp_valid[1]), .rsp_id(o_rsp_id[1]), .rsp_data(o_rsp_data[1]), .rsp_ready(rsp_ready)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_zero(o_rsp_zero[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles left until the result is sampled, and whether a result is being held.
  int         m_left [NI];
  bit         m_hold [NI];
  bit         m_last [NI];
  bit         m_id [NI];
  bit         m_zero [NI];
  logic [2:0] m_op [NI];
  logic [7:0] m_a [NI];
  logic [7:0] m_b [NI];
  logic [7:0] m_data [NI];

  always @(negedge clk) begin : cmp
    bit idle, any, g, e0, e1;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_left[i] = 0; m_hold[i] = 0; m_last[i] = 1; m_id[i] = 0; m_zero[i] = 0;
        m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_data[i] = 0;
        e0 = 0; e1 = 0;
      end else begin
        idle = (m_left[i] == 0) && !m_hold[i];
        any  = req0_valid || req1_valid;
        g    = (req0_valid && req1_valid) ? !m_last[i] : req1_valid;
        e0   = idle && req0_valid && !g;
        e1   = idle && req1_valid && g;
      end
      chk($sformatf("u%0d.req0_ready", i), o_r0_ready[i], e0);
      chk($sformatf("u%0d.req1_ready", i), o_r1_ready[i], e1);
      chk($sformatf("u%0d.alu_op", i), o_alu_op[i], m_op[i]);
      chk($sformatf("u%0d.alu_a", i), o_alu_a[i], m_a[i]);
      chk($sformatf("u%0d.alu_b", i), o_alu_b[i], m_b[i]);
      chk($sformatf("u%0d.rsp_valid", i), o_rsp_valid[i], m_hold[i]);
      chk($sformatf("u%0d.rsp_id", i), o_rsp_id[i], m_id[i]);
      chk($sformatf("u%0d.rsp_data", i), o_rsp_data[i], m_data[i]);
`ifdef ALU_ARB_FLAGS_EN
      chk($sformatf("u%0d.rsp_zero", i), o_rsp_zero[i], m_zero[i]);
`endif
      if (rst_n) begin
        if (idle && any) begin
          m_op[i] = g ? req1_op : req0_op;
          m_a[i]  = g ? req1_a : req0_a;
          m_b[i]  = g ? req1_b : req0_b;
          m_id[i] = g;
          m_last[i] = g;
          m_left[i] = (i == 0) ? LAT0 : LAT1;
        end else if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_data[i] = alu_f(m_op[i], m_a[i], m_b[i]);
            m_zero[i] = (m_data[i] == 8'h00);
            m_hold[i] = 1;
          end
        end else if (m_hold[i] && rsp_ready) begin
          m_hold[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    int  ngr;
    bit  prev;
    bit  cur;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive0(1'b1, 3'd3, 8'hF0, 8'h3C);
    drive1(1'b1, 3'd4, 8'h11, 8'h22);
    #1;
    chk("rst.req0_ready", o_r0_ready[0], 0);
    chk("rst.req1_ready", o_r1_ready[1], 0);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (3) tick();
    chk("rst.u1_alu_a", o_alu_a[1], 8'h00);
    chk("rst.u0_rsp_valid", o_rsp_valid[0], 0);
    rst_n = 1'b1;
    tick();

    // Single request, ALU_LAT 1 and 3.
    rsp_ready = 1'b1;
    drive0(1'b1, 3'd3, 8'hF0, 8'h3C);
    #1;
    chk("single.u0_req0_ready", o_r0_ready[0], 1);
    chk("single.u0_req1_ready", o_r1_ready[0], 0);
    tick();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    chk("single.u0_alu_a", o_alu_a[0], 8'hF0);
    chk("single.u0_valid_e0", o_rsp_valid[0], 0);
    tick();
    chk("single.u0_valid_e1", o_rsp_valid[0], 1);
    chk("single.u0_id", o_rsp_id[0], 0);
    chk("single.u0_data", o_rsp_data[0], 8'hCF);
    chk("single.u3_valid_e1", o_rsp_valid[1], 0);
    tick();
    chk("single.u0_consumed", o_rsp_valid[0], 0);
    chk("single.u3_valid_e2", o_rsp_valid[1], 0);
    tick();
    chk("lat3.u3_valid_e3", o_rsp_valid[1], 1);
    chk("lat3.u3_data", o_rsp_data[1], 8'hCF);
    tick();

    // Reset in the middle of an operation.
    drive0(1'b1, 3'd3, 8'hF0, 8'h3C);
    tick();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst.u3_alu_a", o_alu_a[1], 8'h00);
    chk("midrst.u3_alu_op", o_alu_op[1], 3'd0);
    chk("midrst.u0_rsp_valid", o_rsp_valid[0], 0);
    chk("midrst.u0_rsp_data", o_rsp_data[0], 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("midrst.u0_no_rsp", o_rsp_valid[0], 0);
      chk("midrst.u3_no_rsp", o_rsp_valid[1], 0);
    end

    // Backpressure: response held for several cycles, no new grant meanwhile.
    rsp_ready = 1'b0;
    drive1(1'b1, 3'd4, 8'h12, 8'h34);
    #1;
    chk("bp.u0_req1_ready", o_r1_ready[0], 1);
    tick();
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    drive0(1'b1, 3'd0, 8'hAA, 8'h0F);
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp.u0_valid", o_rsp_valid[0], 1);
      chk("bp.u0_id", o_rsp_id[0], 1);
      chk("bp.u0_data", o_rsp_data[0], 8'h46);
      chk("bp.u0_no_grant", o_r0_ready[0], 0);
      chk("bp.u3_data", o_rsp_data[1], 8'h46);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp.u0_released", o_rsp_valid[0], 0);
    chk("bp.u0_idle_grant", o_r0_ready[0], 1);
    tick();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (6) tick();

    // Contention: both held valid, grants must alternate.
    ngr = 0;
    prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive0(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      drive1(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      #1;
      if (o_r0_ready[0] || o_r1_ready[0]) begin
        cur = o_r1_ready[0];
        if (ngr > 0) chk("contend.alternate", cur, !prev);
        prev = cur;
        ngr++;
      end
      tick();
    end
    chk("contend.enough_grants", (ngr >= 10) ? 1 : 0, 1);
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (6) tick();

`ifdef ALU_ARB_FLAGS_EN
    drive0(1'b1, 3'd3, 8'hFF, 8'hFF);
    tick();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("flags.ff_data", o_rsp_data[0], 8'h00);
    chk("flags.ff_zero", o_rsp_zero[0], 1);
    repeat (4) tick();
    drive0(1'b1, 3'd3, 8'h00, 8'h5A);
    tick();
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    chk("flags.00_data", o_rsp_data[0], 8'hFF);
    chk("flags.00_zero", o_rsp_zero[0], 0);
    repeat (4) tick();
`endif

    // Randomized traffic with occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      drive0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      drive1(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    drive1(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
